// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU.
// It holds one registered result until the owning port consumes it.
module alu_arbiter #(
    parameter bit P_FIXED_PRIO = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_a,
    input  logic [31:0] i_req0_b,
    input  logic [3:0]  i_req0_op,
    output logic        o_req0_ready,
    output logic        o_rsp0_valid,
    input  logic        i_rsp0_ready,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_a,
    input  logic [31:0] i_req1_b,
    input  logic [3:0]  i_req1_op,
    output logic        o_req1_ready,
    output logic        o_rsp1_valid,
    input  logic        i_rsp1_ready,
    output logic [31:0] o_rsp_result,
    output logic        o_rsp_zero,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [3:0]  o_alu_op,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_zero
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        rsp_id_r;
    logic        last_grant_r;
    logic [31:0] result_r;
    logic        zero_r;
    logic        held_ready_s;
    logic        can_accept_s;
    logic        grant_s;
    logic        grant_id_s;

    // Ready of the port that owns the held response; the other port's ready is ignored.
    always_comb begin
        held_ready_s = 1'b0;
        if (rsp_id_r) begin
            held_ready_s = i_rsp1_ready;
        end else begin
            held_ready_s = i_rsp0_ready;
        end
    end

    // A new op fits when nothing is held or the held result leaves this cycle.
    always_comb begin
        can_accept_s = 1'b0;
        case (state_r)
            ST_IDLE: can_accept_s = ~i_rst;
            ST_RESP: can_accept_s = ~i_rst & held_ready_s;
            default: can_accept_s = 1'b0;
        endcase
    end

    // Arbitration: on a tie, fixed priority picks port 0, round-robin picks the port not served last.
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
        if (can_accept_s) begin
            if (i_req0_valid && i_req1_valid) begin
                grant_s = 1'b1;
                if (P_FIXED_PRIO) begin
                    grant_id_s = 1'b0;
                end else begin
                    grant_id_s = ~last_grant_r;
                end
            end else if (i_req0_valid) begin
                grant_s    = 1'b1;
                grant_id_s = 1'b0;
            end else if (i_req1_valid) begin
                grant_s    = 1'b1;
                grant_id_s = 1'b1;
            end else begin
                grant_s    = 1'b0;
                grant_id_s = 1'b0;
            end
        end else begin
            grant_s    = 1'b0;
            grant_id_s = 1'b0;
        end
    end

    // Operand mux toward the shared ALU; quiet zeros when nothing is granted.
    always_comb begin
        o_alu_a  = 32'd0;
        o_alu_b  = 32'd0;
        o_alu_op = 4'b0000;
        if (grant_s && grant_id_s) begin
            o_alu_a  = i_req1_a;
            o_alu_b  = i_req1_b;
            o_alu_op = i_req1_op;
        end else if (grant_s) begin
            o_alu_a  = i_req0_a;
            o_alu_b  = i_req0_b;
            o_alu_op = i_req0_op;
        end else begin
            o_alu_a  = 32'd0;
            o_alu_b  = 32'd0;
            o_alu_op = 4'b0000;
        end
    end

    // Next-state logic: a grant always lands in RESP, a consumed result without a grant drops to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (grant_s) begin
                    state_nxt_s = ST_RESP;
                end else if (held_ready_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, ownership and result registers; last_grant starts at 1 so port 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            rsp_id_r     <= 1'b0;
            last_grant_r <= 1'b1;
            result_r     <= 32'd0;
            zero_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                rsp_id_r     <= grant_id_s;
                last_grant_r <= grant_id_s;
                result_r     <= i_alu_result;
                zero_r       <= i_alu_zero;
            end
        end
    end

    assign o_req0_ready = grant_s & ~grant_id_s;
    assign o_req1_ready = grant_s & grant_id_s;
    assign o_rsp0_valid = (state_r == ST_RESP) & ~rsp_id_r;
    assign o_rsp1_valid = (state_r == ST_RESP) & rsp_id_r;
    assign o_rsp_result = result_r;
    assign o_rsp_zero   = zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority
// instance share stimulus; each drives its own small ALU stand-in.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        v0, v1, rr0, rr1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;

    logic        rdy0, rdy1, rv0, rv1, zero, alu_z;
    logic [31:0] res, alu_a, alu_b, alu_res;
    logic [3:0]  alu_op;

    logic        f_rdy0, f_rdy1, f_rv0, f_rv1, f_zero, f_alu_z;
    logic [31:0] f_res, f_alu_a, f_alu_b, f_alu_res;
    logic [3:0]  f_alu_op;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: op 0 = ADD, op 1 = SUB, otherwise AND.
    always_comb begin
        case (alu_op)
            4'd0:    alu_res = alu_a + alu_b;
            4'd1:    alu_res = alu_a - alu_b;
            default: alu_res = alu_a & alu_b;
        endcase
        alu_z = (alu_res == 32'd0);
    end

    always_comb begin
        case (f_alu_op)
            4'd0:    f_alu_res = f_alu_a + f_alu_b;
            4'd1:    f_alu_res = f_alu_a - f_alu_b;
            default: f_alu_res = f_alu_a & f_alu_b;
        endcase
        f_alu_z = (f_alu_res == 32'd0);
    end

    alu_arbiter #(.P_FIXED_PRIO(1'b0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_op(op0),
        .o_req0_ready(rdy0), .o_rsp0_valid(rv0), .i_rsp0_ready(rr0),
        .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_op(op1),
        .o_req1_ready(rdy1), .o_rsp1_valid(rv1), .i_rsp1_ready(rr1),
        .o_rsp_result(res), .o_rsp_zero(zero),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_res), .i_alu_zero(alu_z)
    );

    alu_arbiter #(.P_FIXED_PRIO(1'b1)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_op(op0),
        .o_req0_ready(f_rdy0), .o_rsp0_valid(f_rv0), .i_rsp0_ready(rr0),
        .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_op(op1),
        .o_req1_ready(f_rdy1), .o_rsp1_valid(f_rv1), .i_rsp1_ready(rr1),
        .o_rsp_result(f_res), .o_rsp_zero(f_zero),
        .o_alu_a(f_alu_a), .o_alu_b(f_alu_b), .o_alu_op(f_alu_op),
        .i_alu_result(f_alu_res), .i_alu_zero(f_alu_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        a0 = 32'd0; b0 = 32'd0; op0 = 4'd0;
        a1 = 32'd0; b1 = 32'd0; op1 = 4'd0;
        tick();
        // Requests during reset must not be granted
        v0 = 1'b1; a0 = 32'd9; b0 = 32'd9;
        #1;
        chk("rst_ready0", {31'd0, rdy0}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        tick();
        chk("rst_result", res, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_rv0", {31'd0, rv0}, 32'd0);
        chk("rst_rv1", {31'd0, rv1}, 32'd0);
        rst = 1'b0;

        // Single request: 5 + 7
        v0 = 1'b1; a0 = 32'd5; b0 = 32'd7; op0 = 4'd0; rr0 = 1'b1;
        #1;
        chk("single_ready0", {31'd0, rdy0}, 32'd1);
        chk("single_ready1", {31'd0, rdy1}, 32'd0);
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd7);
        tick();
        v0 = 1'b0;
        chk("single_rv0", {31'd0, rv0}, 32'd1);
        chk("single_rv1", {31'd0, rv1}, 32'd0);
        chk("single_result", res, 32'd12);
        chk("single_zero", {31'd0, zero}, 32'd0);
        #1;
        chk("idle_alu_a", alu_a, 32'd0);
        tick();
        chk("drain_rv0", {31'd0, rv0}, 32'd0);
        chk("drain_result_held", res, 32'd12);

        // Tie after reset: port 0 SUB 3-3 first, then alternation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v0 = 1'b1; a0 = 32'd3; b0 = 32'd3; op0 = 4'd1;
        v1 = 1'b1; a1 = 32'd1; b1 = 32'd1; op1 = 4'd0;
        rr0 = 1'b1; rr1 = 1'b1;
        #1;
        chk("tie1_ready0", {31'd0, rdy0}, 32'd1);
        chk("tie1_ready1", {31'd0, rdy1}, 32'd0);
        chk("tie1_alu_op", {28'd0, alu_op}, 32'd1);
        tick();
        chk("tie1_rv0", {31'd0, rv0}, 32'd1);
        chk("tie1_result", res, 32'd0);
        chk("tie1_zero", {31'd0, zero}, 32'd1);
        a0 = 32'd10; b0 = 32'd4; op0 = 4'd1;
        #1;
        chk("tie2_ready1", {31'd0, rdy1}, 32'd1);
        chk("tie2_ready0", {31'd0, rdy0}, 32'd0);
        tick();
        chk("tie2_rv1", {31'd0, rv1}, 32'd1);
        chk("tie2_rv0", {31'd0, rv0}, 32'd0);
        chk("tie2_result", res, 32'd2);
        chk("tie2_zero", {31'd0, zero}, 32'd0);
        a1 = 32'd2; b1 = 32'd2; op1 = 4'd0;
        #1;
        chk("tie3_ready0", {31'd0, rdy0}, 32'd1);
        chk("tie3_ready1", {31'd0, rdy1}, 32'd0);
        tick();
        chk("tie3_result", res, 32'd6);
        chk("tie3_rv0", {31'd0, rv0}, 32'd1);
        v0 = 1'b0;
        #1;
        chk("tie4_ready1", {31'd0, rdy1}, 32'd1);
        tick();
        chk("tie4_result", res, 32'd4);
        chk("tie4_rv1", {31'd0, rv1}, 32'd1);
        v1 = 1'b0;
        tick();

        // Backpressure: port 1 result held for 3 cycles while port 0 waits
        v1 = 1'b1; a1 = 32'd20; b1 = 32'd22; op1 = 4'd0; rr1 = 1'b0; rr0 = 1'b1;
        #1;
        chk("bp_ready1", {31'd0, rdy1}, 32'd1);
        tick();
        v1 = 1'b0;
        v0 = 1'b1; a0 = 32'd100; b0 = 32'd1; op0 = 4'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0_low", {31'd0, rdy0}, 32'd0);
            chk("bp_rv1_held", {31'd0, rv1}, 32'd1);
            chk("bp_result_stable", res, 32'd42);
            tick();
        end
        rr1 = 1'b1;
        #1;
        chk("bp_release_ready0", {31'd0, rdy0}, 32'd1);
        chk("bp_release_alu_a", alu_a, 32'd100);
        tick();
        v0 = 1'b0; rr1 = 1'b0;
        chk("bp_rv0", {31'd0, rv0}, 32'd1);
        chk("bp_rv1_low", {31'd0, rv1}, 32'd0);
        chk("bp_result", res, 32'd99);
        tick();
        chk("bp_idle_rv0", {31'd0, rv0}, 32'd0);

        // Back-to-back: four ADDs in four consecutive cycles
        rr0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v0 = 1'b1; a0 = k + 1; b0 = 10 * k; op0 = 4'd0;
            #1;
            chk("b2b_ready0", {31'd0, rdy0}, 32'd1);
            tick();
            chk("b2b_rv0", {31'd0, rv0}, 32'd1);
            chk("b2b_result", res, 11 * k + 1);
        end
        v0 = 1'b0;
        tick();
        chk("b2b_idle", {31'd0, rv0}, 32'd0);

        // Fixed priority: port 0 wins every tie until it drops valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr0 = 1'b1; rr1 = 1'b1;
        v1 = 1'b1; a1 = 32'd7; b1 = 32'd8; op1 = 4'd0;
        for (int k = 0; k < 3; k++) begin
            v0 = 1'b1; a0 = k; b0 = 32'd1; op0 = 4'd0;
            #1;
            chk("fp_ready0", {31'd0, f_rdy0}, 32'd1);
            chk("fp_ready1", {31'd0, f_rdy1}, 32'd0);
            tick();
            chk("fp_rv0", {31'd0, f_rv0}, 32'd1);
            chk("fp_result", f_res, k + 1);
        end
        v0 = 1'b0;
        #1;
        chk("fp_port1_ready", {31'd0, f_rdy1}, 32'd1);
        tick();
        chk("fp_port1_rv1", {31'd0, f_rv1}, 32'd1);
        chk("fp_port1_result", f_res, 32'd15);
        v1 = 1'b0;
        tick();
        tick();

        // Reset while a response is held discards it
        v0 = 1'b1; a0 = 32'd9; b0 = 32'd9; op0 = 4'd0; rr0 = 1'b0;
        tick();
        v0 = 1'b0;
        chk("rr_held_rv0", {31'd0, rv0}, 32'd1);
        chk("rr_held_result", res, 32'd18);
        rst = 1'b1; v0 = 1'b1;
        #1;
        chk("rr_no_grant", {31'd0, rdy0}, 32'd0);
        tick();
        rst = 1'b0; v0 = 1'b0;
        chk("rr_rv0_cleared", {31'd0, rv0}, 32'd0);
        chk("rr_result_cleared", res, 32'd0);
        chk("rr_zero_cleared", {31'd0, zero}, 32'd0);
        v0 = 1'b1; a0 = 32'd1; b0 = 32'd1; op0 = 4'd0;
        v1 = 1'b1; a1 = 32'd5; b1 = 32'd5; op1 = 4'd0;
        rr0 = 1'b1; rr1 = 1'b1;
        #1;
        chk("rr_tie_ready0", {31'd0, rdy0}, 32'd1);
        chk("rr_tie_ready1", {31'd0, rdy1}, 32'd0);
        tick();
        chk("rr_tie_rv0", {31'd0, rv0}, 32'd1);
        chk("rr_tie_result", res, 32'd2);
        v0 = 1'b0; v1 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
